core_lsu_rsp_queue: RTL and testbench
=====================================

Name: core_lsu_rsp_queue

Overview:
- Parametrised data-memory response tracker and load-data formatter for the writeback side of the pipeline.
- Records metadata for every granted dmem request, up to DEPTH outstanding, and matches in-order responses arriving after any latency of 1 or more cycles.
- Aligns, masks and sign-extends load data for XLEN of 32 or 64, and presents one completed result per entry through a valid/ready port.
- Flush discards in-flight requests, and their late responses are absorbed silently.

Parameters:
XLEN, 64, data/memory width in bits; legal values 32 and 64.
DEPTH, 4, maximum outstanding tracked requests; power of two, 2 or more.
RD_W, 5, destination register address width.

Ports:
g_clk  input  1  global clock
g_resetn  input  1  synchronous active-low reset
flush  input  1  discard all tracked requests (trap / control flow change)
req_valid  input  1  dmem request granted this cycle (dmem_req && dmem_gnt)
req_ready  output  1  space available; the requester must not issue a dmem_req while low
req_load  input  1  request is a load
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = double
req_sext  input  1  sign-extend load result
req_offset  input  $clog2(XLEN/8)  byte offset of the access within the data word
req_rd  input  RD_W  load destination register
dmem_rvalid  input  1  memory response valid
dmem_err  input  1  response error
dmem_rdata  input  XLEN  response read data
out_valid  output  1  head entry complete
out_ready  input  1  consumer accepts head entry
out_wen  output  1  GPR write required (load without error)
out_rd  output  RD_W  destination register
out_rdata  output  XLEN  formatted load data; 0 for stores and errors
out_err  output  1  access fault
out_cause  output  6  5 (load access fault) or 7 (store access fault) when out_err, else 0
outstanding  output  $clog2(DEPTH)+1  live entries plus pending drops

Behaviour:
- Reset (g_resetn=0 at a clock edge): all pointers, entry states and drop_cnt cleared. Outputs reset to out_valid=0, req_ready=1, outstanding=0; out_wen, out_err, out_cause and out_rdata all 0.
- Circular buffer of DEPTH entries with tail (enqueue), rsp_ptr (next entry awaiting response) and head (next entry to output). Pointers wrap modulo DEPTH.
- Each entry is in one of three states: FREE, PEND (awaiting response) or DONE (data/err captured).
- Enqueue: when req_valid is high, entry[tail] becomes PEND with its metadata stored, and tail advances.
- req_ready = (live entries + drop_cnt) < DEPTH. Asserting req_valid while req_ready is low is illegal; the bench must flag it.
- Response: on dmem_rvalid with drop_cnt=0, entry[rsp_ptr] captures formatted data and dmem_err, goes to DONE, and rsp_ptr advances.
- Response with drop_cnt>0: the response is discarded and drop_cnt decrements.
- dmem_rvalid with no PEND entry and drop_cnt=0 is illegal.
- Latency: a response at cycle N gives out_valid=1 at cycle N+1. There is no combinational path from dmem_* to the out_* ports.
- Formatting:
  - shifted = dmem_rdata >> (offset*8).
  - Result is masked to the size width, and bits above it are filled with the size MSB when req_sext=1, else 0.
  - Size 3 with XLEN=64 returns the full word unshifted. Size 3 with XLEN=32 is treated as a word access.
- Output: out_valid = (entry[head] == DONE). On out_valid && out_ready the entry goes to FREE and head advances.
- out_wen = load && !err; out_rdata = 0 unless out_wen.
- Simultaneous events: enqueue, response and dequeue may all occur in one cycle. A full buffer with a dequeue and enqueue in the same cycle does not fault, because req_ready is computed on the current state (no same-cycle credit).
- Flush, applied at the clock edge:
  - All entries become FREE and all pointers reset to 0, discarding DONE entries too.
  - drop_cnt' = drop_cnt + (#PEND entries) + req_valid − dmem_rvalid.
  - A request granted in the flush cycle is therefore dropped, and a response arriving in the flush cycle is discarded.
  - out_valid = 0 in the cycle after flush.
- Requests issued after a flush may enqueue while drops are still draining. Because responses are in order, they are matched only once drop_cnt reaches 0.
- outstanding = live entries + drop_cnt; this never exceeds DEPTH.

Test Plan:
1. XLEN=64: lb, offset 3, sext=1, rdata=0x00000000_80FF0000 → out_rdata=0xFFFFFFFF_FFFFFF80, out_wen=1, out_rd echoes req_rd.
2. Four back-to-back loads with response latencies 1, 3, 1, 2 and out_ready held low → req_ready=0 after the 4th request; releasing out_ready drains the results in issue order.
3. Store response with dmem_err=1 → out_err=1, out_cause=7, out_wen=0, out_rdata=0. A load with an error gives out_cause=5.
4. Flush with 3 PEND entries plus req_valid in the same cycle → outstanding=4. The next 4 responses are dropped; the 5th completes a post-flush load correctly.
5. XLEN=32: lhu, offset 2, rdata=0xBEEF1234 → out_rdata=0x0000BEEF. lh with the same inputs → 0xFFFFBEEF.
6. Reset asserted with 2 PEND and 1 DONE entries → next cycle out_valid=0, outstanding=0, req_ready=1.

Source files
------------

// File: rtl/core_lsu_rsp_queue.sv
// Data-memory response tracker: records granted dmem requests, matches in-order
// responses, formats load data and hands one result per entry to writeback.
module core_lsu_rsp_queue #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    parameter int RD_W  = 5
) (
    input  logic                      g_clk,
    input  logic                      g_resetn,
    input  logic                      flush,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_load,
    input  logic [1:0]                req_size,
    input  logic                      req_sext,
    input  logic [$clog2(XLEN/8)-1:0] req_offset,
    input  logic [RD_W-1:0]           req_rd,
    input  logic                      dmem_rvalid,
    input  logic                      dmem_err,
    input  logic [XLEN-1:0]           dmem_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_wen,
    output logic [RD_W-1:0]           out_rd,
    output logic [XLEN-1:0]           out_rdata,
    output logic                      out_err,
    output logic [5:0]                out_cause,
    output logic [$clog2(DEPTH):0]    outstanding
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(XLEN/8);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {ENT_FREE, ENT_PEND, ENT_DONE} ent_st_t;

    ent_st_t         ent_st   [DEPTH];
    logic            ent_load [DEPTH];
    logic [1:0]      ent_size [DEPTH];
    logic            ent_sext [DEPTH];
    logic [OW-1:0]   ent_off  [DEPTH];
    logic [RD_W-1:0] ent_rd   [DEPTH];
    logic [XLEN-1:0] ent_data [DEPTH];
    logic            ent_err  [DEPTH];

    logic [PW-1:0]   tail;
    logic [PW-1:0]   rsp_ptr;
    logic [PW-1:0]   head;
    logic [CW-1:0]   live_cnt;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   pend_cnt;
    logic            rsp_take;
    logic            deq;

    logic [XLEN-1:0] fmt_data;
    logic [XLEN-1:0] shifted;
    logic [1:0]      eff_size;
    int unsigned     width;

    // Format against the metadata of the entry this response belongs to.
    always_comb begin
        eff_size = ent_size[rsp_ptr];
        if (XLEN == 32 && eff_size == 2'd3)
            eff_size = 2'd2;
        shifted  = dmem_rdata >> {ent_off[rsp_ptr], 3'b000};
        width    = 32'd8 << eff_size;
        fmt_data = '0;
        if (eff_size == 2'd3) begin
            fmt_data = dmem_rdata;
        end else begin
            for (int unsigned i = 0; i < XLEN; i++)
                fmt_data[i] = (i < width) ? shifted[i]
                                          : (ent_sext[rsp_ptr] & shifted[width-1]);
        end
    end

    always_comb begin
        pend_cnt = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            if (ent_st[i] == ENT_PEND)
                pend_cnt = pend_cnt + CW'(1);
    end

    assign rsp_take    = dmem_rvalid && (drop_cnt == '0);
    assign out_valid   = (ent_st[head] == ENT_DONE);
    assign deq         = out_valid && out_ready;
    assign outstanding = live_cnt + drop_cnt;
    assign req_ready   = (outstanding < CW'(DEPTH));

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            tail     <= '0;
            rsp_ptr  <= '0;
            head     <= '0;
            live_cnt <= '0;
            drop_cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                ent_st[i] <= ENT_FREE;
        end else if (flush) begin
            // Every request still owed a response, including one granted now,
            // becomes a drop; a response arriving now settles one of them.
            tail     <= '0;
            rsp_ptr  <= '0;
            head     <= '0;
            live_cnt <= '0;
            drop_cnt <= drop_cnt + pend_cnt + CW'(req_valid) - CW'(dmem_rvalid);
            for (int unsigned i = 0; i < DEPTH; i++)
                ent_st[i] <= ENT_FREE;
        end else begin
            if (req_valid) begin
                ent_st[tail]   <= ENT_PEND;
                ent_load[tail] <= req_load;
                ent_size[tail] <= req_size;
                ent_sext[tail] <= req_sext;
                ent_off[tail]  <= req_offset;
                ent_rd[tail]   <= req_rd;
                tail           <= tail + PW'(1);
            end
            if (rsp_take) begin
                ent_st[rsp_ptr]   <= ENT_DONE;
                ent_data[rsp_ptr] <= fmt_data;
                ent_err[rsp_ptr]  <= dmem_err;
                rsp_ptr           <= rsp_ptr + PW'(1);
            end else if (dmem_rvalid) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (deq) begin
                ent_st[head] <= ENT_FREE;
                head         <= head + PW'(1);
            end
            live_cnt <= live_cnt + CW'(req_valid) - CW'(deq);
        end
    end

    assign out_rd    = ent_rd[head];
    assign out_err   = out_valid && ent_err[head];
    assign out_wen   = out_valid && ent_load[head] && !ent_err[head];
    assign out_rdata = out_wen ? ent_data[head] : '0;
    assign out_cause = out_err ? (ent_load[head] ? 6'd5 : 6'd7) : 6'd0;

endmodule

// File: tb/tb_core_lsu_rsp_queue.sv
// Scoreboard bench for core_lsu_rsp_queue: a 64-bit and a 32-bit instance,
// a scheduled in-order memory responder and per-instance expected-result queues.
module tb_core_lsu_rsp_queue;
    logic        g_clk = 1'b0;
    logic        g_resetn, flush, out_ready;
    logic        req_valid, req_valid_n, req_load, req_sext;
    logic [1:0]  req_size;
    logic [2:0]  req_offset;
    logic [4:0]  req_rd;
    logic        dmem_rvalid, dmem_rvalid_n, dmem_err;
    logic [63:0] dmem_rdata;

    logic        req_ready, out_valid, out_wen, out_err;
    logic [4:0]  out_rd;
    logic [63:0] out_rdata;
    logic [5:0]  out_cause;
    logic [2:0]  outstanding;

    logic        req_ready_n, out_valid_n, out_wen_n, out_err_n;
    logic [4:0]  out_rd_n;
    logic [31:0] out_rdata_n;
    logic [5:0]  out_cause_n;
    logic [2:0]  outstanding_n;

    typedef struct { int due; logic n; logic [63:0] data; logic err; } rsp_t;
    typedef struct { logic wen; logic [4:0] rd; logic [63:0] rdata; logic err; logic [5:0] cause; } exp_t;

    rsp_t rq[$];
    exp_t exp_w[$];
    exp_t exp_n[$];
    exp_t ew, en;
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, last_due = 0;
    logic rnd_ready = 1'b0;

    core_lsu_rsp_queue #(.XLEN(64), .DEPTH(4), .RD_W(5)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_size(req_size), .req_sext(req_sext), .req_offset(req_offset),
        .req_rd(req_rd), .dmem_rvalid(dmem_rvalid), .dmem_err(dmem_err),
        .dmem_rdata(dmem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_wen(out_wen), .out_rd(out_rd), .out_rdata(out_rdata),
        .out_err(out_err), .out_cause(out_cause), .outstanding(outstanding)
    );

    core_lsu_rsp_queue #(.XLEN(32), .DEPTH(4), .RD_W(5)) dut_n (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
        .req_valid(req_valid_n), .req_ready(req_ready_n), .req_load(req_load),
        .req_size(req_size), .req_sext(req_sext), .req_offset(req_offset[1:0]),
        .req_rd(req_rd), .dmem_rvalid(dmem_rvalid_n), .dmem_err(dmem_err),
        .dmem_rdata(dmem_rdata[31:0]), .out_valid(out_valid_n), .out_ready(out_ready),
        .out_wen(out_wen_n), .out_rd(out_rd_n), .out_rdata(out_rdata_n),
        .out_err(out_err_n), .out_cause(out_cause_n), .outstanding(outstanding_n)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] fmt(input int xl, input logic [1:0] sz, input logic sx,
                                        input logic [2:0] off, input logic [63:0] d);
        logic [63:0] s, r;
        logic [1:0]  z;
        z = (xl == 32 && sz == 2'd3) ? 2'd2 : sz;
        if (z == 2'd3) return d;
        s = d >> (8 * off);
        case (z)
            2'd0:    r = sx ? 64'($signed(s[7:0]))  : 64'(s[7:0]);
            2'd1:    r = sx ? 64'($signed(s[15:0])) : 64'(s[15:0]);
            default: r = sx ? 64'($signed(s[31:0])) : 64'(s[31:0]);
        endcase
        if (xl == 32) r[63:32] = '0;
        return r;
    endfunction

    task automatic step();
        rsp_t r;
        @(posedge g_clk);
        #1;
        cyc++;
        req_valid     = 1'b0;
        req_valid_n   = 1'b0;
        flush         = 1'b0;
        dmem_rvalid   = 1'b0;
        dmem_rvalid_n = 1'b0;
        dmem_err      = 1'b0;
        dmem_rdata    = {$urandom, $urandom};
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            if (r.n) dmem_rvalid_n = 1'b1;
            else     dmem_rvalid   = 1'b1;
            dmem_err   = r.err;
            dmem_rdata = r.data;
        end
    endtask

    task automatic issue(input logic n, input logic ld, input logic [1:0] sz, input logic sx,
                         input logic [2:0] off, input logic [4:0] rd, input logic [63:0] data,
                         input logic err, input int lat, input logic [63:0] expd, input logic track);
        int   k = 0;
        rsp_t r;
        exp_t e;
        while (!(n ? req_ready_n : req_ready) && k < 100) begin
            step();
            k++;
        end
        if (k == 100) chk("req_ready_timeout", 64'd0, 64'd1);
        req_load   = ld;
        req_size   = sz;
        req_sext   = sx;
        req_offset = off;
        req_rd     = rd;
        if (n) req_valid_n = 1'b1;
        else   req_valid   = 1'b1;
        r.due    = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        last_due = r.due;
        r.n      = n;
        r.data   = data;
        r.err    = err;
        rq.push_back(r);
        if (track) begin
            e.wen   = ld && !err;
            e.rd    = rd;
            e.rdata = e.wen ? expd : 64'd0;
            e.err   = err;
            e.cause = err ? (ld ? 6'd5 : 6'd7) : 6'd0;
            if (n) exp_n.push_back(e);
            else   exp_w.push_back(e);
        end
        step();
    endtask

    task automatic drain();
        int k = 0;
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        while ((rq.size() != 0 || exp_w.size() != 0 || exp_n.size() != 0) && k < 300) begin
            step();
            k++;
        end
        chk("drain_timeout", 64'(k == 300), 64'd0);
        step();
    endtask

    always @(negedge g_clk) begin
        if (g_resetn) begin
            if (req_valid)   chk("req_legal_w", 64'(req_ready), 64'd1);
            if (req_valid_n) chk("req_legal_n", 64'(req_ready_n), 64'd1);
            if (out_valid && out_ready) begin
                if (exp_w.size() == 0) chk("spurious_out_w", 64'd1, 64'd0);
                else begin
                    ew = exp_w.pop_front();
                    chk("wen_w",   64'(out_wen),   64'(ew.wen));
                    chk("rd_w",    64'(out_rd),    64'(ew.rd));
                    chk("rdata_w", out_rdata,      ew.rdata);
                    chk("err_w",   64'(out_err),   64'(ew.err));
                    chk("cause_w", 64'(out_cause), 64'(ew.cause));
                end
            end
            if (out_valid_n && out_ready) begin
                if (exp_n.size() == 0) chk("spurious_out_n", 64'd1, 64'd0);
                else begin
                    en = exp_n.pop_front();
                    chk("wen_n",   64'(out_wen_n),   64'(en.wen));
                    chk("rd_n",    64'(out_rd_n),    64'(en.rd));
                    chk("rdata_n", 64'(out_rdata_n), en.rdata);
                    chk("err_n",   64'(out_err_n),   64'(en.err));
                    chk("cause_n", 64'(out_cause_n), 64'(en.cause));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        logic [1:0]  sz;
        logic [2:0]  off;
        logic        sx, ld, er, nn;
        g_resetn = 1'b0; flush = 1'b0; out_ready = 1'b0;
        req_valid = 1'b0; req_valid_n = 1'b0; req_load = 1'b0; req_sext = 1'b0;
        req_size = 2'd0; req_offset = 3'd0; req_rd = 5'd0;
        dmem_rvalid = 1'b0; dmem_rvalid_n = 1'b0; dmem_err = 1'b0; dmem_rdata = '0;
        step(); step();
        chk("rst_out_valid",   64'(out_valid),   64'd0);
        chk("rst_req_ready",   64'(req_ready),   64'd1);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_out_wen",     64'(out_wen),     64'd0);
        chk("rst_out_err",     64'(out_err),     64'd0);
        chk("rst_out_cause",   64'(out_cause),   64'd0);
        chk("rst_out_rdata",   out_rdata,        64'd0);
        chk("rst_out_valid_n", 64'(out_valid_n), 64'd0);
        g_resetn = 1'b1;
        step();

        // lb, offset 3, sign-extended; result visible one cycle after the response
        out_ready = 1'b1;
        issue(0, 1, 2'd0, 1, 3'd3, 5'd9, 64'h0000_0000_80FF_0000, 0, 1, 64'hFFFF_FFFF_FFFF_FF80, 1);
        chk("lat_rsp_cycle", 64'(out_valid), 64'd0);
        step();
        chk("lat_next_cycle", 64'(out_valid), 64'd1);
        drain();

        // four back-to-back loads, consumer stalled
        out_ready = 1'b0;
        begin
            int lats[4] = '{1, 3, 1, 2};
            for (int i = 0; i < 4; i++) begin
                d   = {$urandom, $urandom};
                off = 3'($urandom_range(0, 7));
                sx  = 1'($urandom_range(0, 1));
                sz  = 2'(i);
                issue(0, 1, sz, sx, off, 5'(i + 1), d, 0, lats[i], fmt(64, sz, sx, off, d), 1);
            end
        end
        chk("full_req_ready", 64'(req_ready), 64'd0);
        for (int i = 0; i < 8; i++) step();
        chk("full_outstanding", 64'(outstanding), 64'd4);
        chk("full_stalled_valid", 64'(out_valid), 64'd1);
        drain();

        // error responses
        issue(0, 0, 2'd2, 0, 3'd4, 5'd3, 64'h1234, 1, 2, 64'd0, 1);
        issue(0, 1, 2'd3, 0, 3'd0, 5'd4, 64'h5678, 1, 1, 64'd0, 1);
        drain();

        // flush with three pending plus a grant in the flush cycle
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            issue(0, 1, 2'd3, 0, 3'd0, 5'(10 + i), 64'hDEAD, 0, 20, 64'd0, 0);
        flush = 1'b1;
        issue(0, 1, 2'd3, 0, 3'd0, 5'd13, 64'hBEEF, 0, 1, 64'd0, 0);
        chk("flush_outstanding", 64'(outstanding), 64'd4);
        chk("flush_out_valid",   64'(out_valid),   64'd0);
        chk("flush_req_ready",   64'(req_ready),   64'd0);
        issue(0, 1, 2'd1, 1, 3'd2, 5'd21, 64'h0000_0000_8001_0000, 0, 1, 64'hFFFF_FFFF_FFFF_8001, 1);
        drain();
        chk("post_flush_outstanding", 64'(outstanding), 64'd0);

        // flush discards a completed entry
        out_ready = 1'b0;
        issue(0, 1, 2'd3, 0, 3'd0, 5'd7, 64'h77, 0, 1, 64'd0, 0);
        step();
        chk("done_before_flush", 64'(out_valid), 64'd1);
        flush = 1'b1;
        step();
        chk("flush_done_valid", 64'(out_valid),   64'd0);
        chk("flush_done_outst", 64'(outstanding), 64'd0);

        // 32-bit instance
        issue(1, 1, 2'd1, 0, 3'd2, 5'd5, 64'hBEEF_1234, 0, 1, 64'h0000_BEEF, 1);
        issue(1, 1, 2'd1, 1, 3'd2, 5'd6, 64'hBEEF_1234, 0, 1, 64'hFFFF_BEEF, 1);
        issue(1, 1, 2'd3, 1, 3'd0, 5'd7, 64'h89AB_CDEF, 0, 2, 64'h89AB_CDEF, 1);
        drain();

        // random mix on both instances with a randomly stalling consumer
        rnd_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            nn  = ($urandom_range(0, 3) == 0);
            ld  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            sx  = 1'($urandom_range(0, 1));
            er  = ($urandom_range(0, 7) == 0);
            off = nn ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            d   = nn ? {32'd0, $urandom} : {$urandom, $urandom};
            issue(nn, ld, sz, sx, off, 5'($urandom_range(0, 31)), d, er,
                  $urandom_range(1, 4), fmt(nn ? 32 : 64, sz, sx, off, d), 1);
            if ($urandom_range(0, 2) == 0) step();
        end
        drain();

        // reset with two pending and one completed entry
        out_ready = 1'b0;
        issue(0, 1, 2'd3, 0, 3'd0, 5'd1, 64'h11, 0, 1, 64'd0, 0);
        issue(0, 1, 2'd3, 0, 3'd0, 5'd2, 64'h22, 0, 30, 64'd0, 0);
        issue(0, 1, 2'd3, 0, 3'd0, 5'd3, 64'h33, 0, 31, 64'd0, 0);
        chk("pre_rst_valid", 64'(out_valid),   64'd1);
        chk("pre_rst_outst", 64'(outstanding), 64'd3);
        g_resetn = 1'b0;
        rq.delete();
        last_due = cyc;
        step();
        g_resetn = 1'b1;
        chk("rst2_out_valid",   64'(out_valid),   64'd0);
        chk("rst2_outstanding", 64'(outstanding), 64'd0);
        chk("rst2_req_ready",   64'(req_ready),   64'd1);
        out_ready = 1'b1;
        issue(0, 1, 2'd2, 0, 3'd4, 5'd30, 64'hCAFE_F00D_0000_0000, 0, 2, 64'h0000_0000_CAFE_F00D, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
